// File: rtl/sprite_plotter.sv
// Sprite plotter: on a plot strobe, latches a cell position and scans a
// SPRITE_W x SPRITE_H pixel box onto the VGA adapter write port, one pixel per cycle.
module sprite_plotter #(
  parameter int unsigned SPRITE_W = 4,
  parameter int unsigned SPRITE_H = 4,
  parameter int unsigned CELL_X_W = 5,
  parameter int unsigned CELL_Y_W = 5,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter logic [2:0] FG_COLOUR = 3'b100,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter logic [SPRITE_W*SPRITE_H-1:0] SPRITE_MASK = 16'h6FF6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                plot,
  input  logic                s_color,
  input  logic [CELL_X_W-1:0] xpos,
  input  logic [CELL_Y_W-1:0] ypos,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [2:0]          vga_colour,
  output logic                vga_write
);

  localparam int unsigned NPIX = SPRITE_W * SPRITE_H;
  localparam int unsigned CW   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int unsigned RW   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int unsigned MW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned OXW  = CELL_X_W + $clog2(SPRITE_W);
  localparam int unsigned OYW  = CELL_Y_W + $clog2(SPRITE_H);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t         state, state_nxt;
  logic [OXW-1:0] ox;
  logic [OYW-1:0] oy;
  logic           sel;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic           last_col;
  logic           last_pix;
  logic [31:0]    px;
  logic [31:0]    py;
  logic [MW-1:0]  idx;
  logic           in_bounds;

  always_comb begin
    last_col = (col == CW'(SPRITE_W - 1));
    last_pix = last_col && (row == RW'(SPRITE_H - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (plot) state_nxt = SCAN;
      SCAN:    if (last_pix) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ox  <= '0;
      oy  <= '0;
      sel <= 1'b0;
      col <= '0;
      row <= '0;
    end else if (state == IDLE && plot) begin
      ox  <= OXW'(32'(xpos) * SPRITE_W);
      oy  <= OYW'(32'(ypos) * SPRITE_H);
      sel <= s_color;
      col <= '0;
      row <= '0;
    end else if (state == SCAN) begin
      if (last_col) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Clip test uses the full-width sums so off-screen pixels never alias on-screen.
  always_comb begin
    px         = 32'(ox) + 32'(col);
    py         = 32'(oy) + 32'(row);
    idx        = MW'(32'(row) * SPRITE_W + 32'(col));
    in_bounds  = (px < SCREEN_W) && (py < SCREEN_H);
    busy       = (state != IDLE);
    done       = (state == DONE);
    overrun    = plot && (state != IDLE);
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_write  = 1'b0;
    if (state == SCAN) begin
      vga_x      = px[7:0];
      vga_y      = py[6:0];
      vga_colour = sel ? FG_COLOUR : BG_COLOUR;
      vga_write  = in_bounds && (sel ? SPRITE_MASK[idx] : 1'b1);
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter: directed and random requests
// compared against an arithmetic pixel model; a second instance uses SCREEN_W=126.
module tb_sprite_plotter;

  localparam int SW = 4;
  localparam int SH = 4;
  localparam int NPIX = SW * SH;

  logic       clk = 1'b0;
  logic       reset, plot, s_color;
  logic [4:0] xpos, ypos;
  logic       busy, done, overrun, vga_write;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       busy2, done2, overrun2, vga_write2;
  logic [7:0] vga_x2;
  logic [6:0] vga_y2;
  logic [2:0] vga_colour2;

  logic [15:0] mask = 16'h6FF6;
  int checks = 0;
  int passed = 0;
  int failed = 0;

  sprite_plotter dut (
    .clk(clk), .reset(reset), .plot(plot), .s_color(s_color),
    .xpos(xpos), .ypos(ypos), .busy(busy), .done(done), .overrun(overrun),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_write(vga_write)
  );

  sprite_plotter #(.SCREEN_W(126)) dut_narrow (
    .clk(clk), .reset(reset), .plot(plot), .s_color(s_color),
    .xpos(xpos), .ypos(ypos), .busy(busy2), .done(done2), .overrun(overrun2),
    .vga_x(vga_x2), .vga_y(vga_y2), .vga_colour(vga_colour2), .vga_write(vga_write2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pixel k of a request at cell (x,y), clipped against screen width sw.
  task automatic model_pix(input int x, input int y, input int sel, input int k, input int sw,
                           output int ex, output int ey, output int ec, output int ew);
    int c, r, fx, fy;
    c  = k % SW;
    r  = k / SW;
    fx = x * SW + c;
    fy = y * SH + r;
    ew = (fx < sw && fy < 120) ? (sel != 0 ? int'(mask[k]) : 1) : 0;
    ex = fx % 256;
    ey = fy % 128;
    ec = (sel != 0) ? 4 : 0;
  endtask

  // Starts at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_request(input int x, input int y, input int sel,
                             input int ov_at, input int rst_at,
                             input int exp_w1, input int exp_w2);
    int ex, ey, ec, ew, ex2, ey2, ec2, ew2;
    int w1 = 0, w2 = 0, m1 = 0, m2 = 0, bcyc = 0, dcount = 0;
    xpos = 5'(x); ypos = 5'(y); s_color = sel[0]; plot = 1'b1;
    #1;
    check("idle_overrun", overrun, 0);
    check("idle_busy", busy, 0);
    for (int k = 0; k <= NPIX; k++) begin
      @(negedge clk);
      plot  = (k == ov_at);
      if (k == ov_at) xpos = 5'd7;
      reset = (k == rst_at);
      #1;
      bcyc += int'(busy);
      if (k < NPIX) begin
        model_pix(x, y, sel, k, 160, ex, ey, ec, ew);
        model_pix(x, y, sel, k, 126, ex2, ey2, ec2, ew2);
        m1 += ew; m2 += ew2;
        w1 += int'(vga_write); w2 += int'(vga_write2);
        check("scan_busy", busy, 1);
        check("scan_done", done, 0);
        check("scan_overrun", overrun, (k == ov_at) ? 1 : 0);
        check("pix_x", vga_x, ex);
        check("pix_y", vga_y, ey);
        check("pix_colour", vga_colour, ec);
        check("pix_write", vga_write, ew);
        check("narrow_write", vga_write2, ew2);
      end else begin
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_write", vga_write, 0);
        check("narrow_done", done2, 1);
      end
      if (k == rst_at) begin
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_write", vga_write, 0);
        check("rst_done", done, 0);
        check("rst_vga_x", vga_x, 0);
        check("rst_narrow_busy", busy2, 0);
        repeat (20) begin
          @(negedge clk);
          #1;
          dcount += int'(done) + int'(busy);
        end
        check("rst_no_done", dcount, 0);
        return;
      end
    end
    @(negedge clk);
    #1;
    check("end_busy", busy, 0);
    check("end_done", done, 0);
    check("end_write", vga_write, 0);
    check("busy_cycles", bcyc, NPIX + 1);
    check("write_count", w1, (exp_w1 >= 0) ? exp_w1 : m1);
    check("narrow_write_count", w2, (exp_w2 >= 0) ? exp_w2 : m2);
  endtask

  initial begin
    reset = 1'b1; plot = 1'b0; s_color = 1'b0; xpos = '0; ypos = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_overrun", overrun, 0);
    check("reset_write", vga_write, 0);
    check("reset_vga_x", vga_x, 0);
    check("reset_vga_y", vga_y, 0);
    check("reset_colour", vga_colour, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_request(2, 3, 1, -1, -1, 12, 12);   // draw at (2,3)
    run_request(2, 3, 0, -1, -1, 16, 16);   // erase at (2,3), back-to-back
    run_request(31, 0, 0, -1, -1, 16, 8);   // right edge; narrow screen clips
    run_request(2, 3, 1, 4, -1, 12, 12);    // overrun mid-scan with xpos=7
    run_request(2, 3, 1, -1, 7, -1, -1);    // reset mid-scan
    run_request(2, 3, 1, -1, -1, 12, 12);   // clean restart after abort
    run_request(0, 31, 0, -1, -1, 0, 0);    // bottom rows fully clipped

    repeat (8) begin
      run_request(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 1)), -1, -1, -1, -1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sprite_plotter.md
# sprite_plotter

Pixel-drawing responder for the maze game controller's `plot` / `s_color` request pair. On a one-cycle `plot` strobe it latches the player's cell position and the erase/draw select. It then scans a SPRITE_W x SPRITE_H pixel box, one pixel per cycle, onto the VGA adapter write port (x, y, colour, write-enable). It sits between the game controller FSM and the VGA adapter and reports `busy` and a `done` pulse back to the controller side.

## Interface
- SPRITE_W, 4: sprite width in pixels; cell-to-pixel x scale.
- SPRITE_H, 4: sprite height in pixels; cell-to-pixel y scale.
- CELL_X_W, 5: width of the `xpos` cell coordinate.
- CELL_Y_W, 5: width of the `ypos` cell coordinate.
- SCREEN_W, 160: visible pixel columns; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120: visible pixel rows; pixels with y >= SCREEN_H are clipped.
- FG_COLOUR, 3'b100: draw colour.
- BG_COLOUR, 3'b000: erase colour.
- SPRITE_MASK, 16'h6FF6: SPRITE_W*SPRITE_H bits; bit index = row*SPRITE_W + col; 1 = opaque.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- plot  in  1  start strobe; sampled only in IDLE.
- s_color  in  1  0 = erase (full box, BG_COLOUR), 1 = draw (masked, FG_COLOUR).
- xpos  in  CELL_X_W  cell column; sampled with `plot`.
- ypos  in  CELL_Y_W  cell row; sampled with `plot`.
- busy  out  1  high while a request is in progress.
- done  out  1  one-cycle completion pulse.
- overrun  out  1  one-cycle pulse when `plot` arrives while not IDLE.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- vga_colour  out  3  pixel colour.
- vga_write  out  1  pixel write enable.

## Operation
- States: IDLE, SCAN, DONE.
- **IDLE.** On `plot`=1, latch the following and go to SCAN:
  - ox = xpos*SPRITE_W and oy = ypos*SPRITE_H, computed at full width (CELL_X_W + clog2(SPRITE_W) bits) with no truncation before clipping;
  - sel = s_color;
  - col = row = 0.
- **SCAN.** Present pixel (ox+col, oy+row) combinationally from the registered counters:
  - vga_x and vga_y are the low 8 and 7 bits of the sums;
  - vga_colour = sel ? FG_COLOUR : BG_COLOUR;
  - vga_write = in_bounds & (sel ? SPRITE_MASK[row*SPRITE_W+col] : 1);
  - in_bounds = (ox+col < SCREEN_W) & (oy+row < SCREEN_H), evaluated on the full-width sums.
- **Counter advance in SCAN.**
  - If col == SPRITE_W-1: col = 0 and row increments; otherwise col increments.
  - At the last pixel (col == SPRITE_W-1, row == SPRITE_H-1), go to DONE.
- **DONE.** `done`=1 for one cycle, then go to IDLE. `plot` is not accepted in DONE.
- Outside SCAN: vga_write=0 and vga_x, vga_y, vga_colour = 0.
- busy = (state != IDLE).
- `plot`=1 while in SCAN or DONE:
  - the request is ignored and the latched values are unchanged;
  - `overrun` pulses in that same cycle.
- Back-to-back requests: `plot` asserted in the cycle after `done` (state IDLE) is accepted normally.

## Timing
- Reset (synchronous, takes priority over everything):
  - state goes to IDLE and counters to 0;
  - busy, done, overrun, vga_write and all vga_* outputs are 0 the cycle after the reset edge.
- Reset during SCAN aborts immediately: no further writes and no `done`.
- `plot` sampled at edge E0 leads to:
  - pixel k presented during the cycle after edge E0+k, for k = 0..N-1 with N = SPRITE_W*SPRITE_H;
  - `done` during the cycle after E0+N;
  - `busy` high for exactly N+1 cycles.
- Default parameters give 16 pixel cycles and 17 busy cycles.
- Throughput: one request per N+1 cycles.
- The controller's timer period must exceed N+1 cycles. `overrun` exposes any violation.
- `overrun` is combinational from `plot` & busy, with no latency.

## Test plan
- **Draw at (2,3).** Defaults, xpos=2, ypos=3, s_color=1, `plot` pulse:
  - 16 SCAN cycles, x stepping 8..11 within each row and y stepping 12..15;
  - vga_write follows mask 16'h6FF6, giving 12 writes of colour 3'b100;
  - `done` in cycle 17; busy high for 17 cycles.
- **Erase at (2,3).** Same request with s_color=0: 16 writes, all with vga_colour=0.
- **Right-edge clipping.** xpos=31, ypos=0, s_color=0:
  - all pixel x values (124..127) are below 160, so all 16 writes occur.
  - Repeat with SCREEN_W=126: only col 0..1 write, giving 8 writes; `done` still arrives in cycle 17.
- **Overrun.** `plot` at SCAN cycle 5 with xpos=7:
  - `overrun` pulses for 1 cycle;
  - the scan continues with the original xpos=2 unchanged;
  - a single `done`.
- **Reset mid-scan.** Reset at SCAN cycle 8:
  - the next cycle has busy=0 and vga_write=0;
  - no `done` is ever produced;
  - a following `plot` starts cleanly from pixel (ox, oy).
- **Back-to-back.** `plot` again in the cycle right after `done`: accepted, no `overrun`, 34 total cycles for two draws.
